telemetry_scheduler: RTL
========================

TELEMETRY_SCHEDULER -- requirements
Module: telemetry_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4096: sample period in Clk cycles; legal range 16..65536.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_enable  input  1  high to allow periodic frames.
REQ-005 SHALL have port i_ch_mask  input  4  channel enables: bit0 velocity, bit1 setpoint, bit2 error, bit3 PID output.
REQ-006 SHALL have ports i_velocity, i_setpoint, i_error, i_un  input  16 each  channel sources, ids 0..3.
REQ-007 SHALL have port i_uart_full  input  1  UART TX FIFO full.
REQ-008 SHALL have port o_uart_data  output  32  word to UART.
REQ-009 SHALL have port o_uart_wr  output  1  one-cycle write strobe.
REQ-010 SHALL have port o_busy  output  1  frame in progress.
REQ-011 SHALL have port o_seq  output  8  sequence number of the next frame.
REQ-012 SHALL have port o_overrun_cnt  output  8  count of dropped ticks.

Function
REQ-013 SHALL keep a tick counter 0..TICK_DIV-1, wrapping; tick = counter==TICK_DIV-1 and i_enable==1.
REQ-014 SHALL hold the tick counter at 0 while i_enable==0; the first tick comes TICK_DIV cycles after i_enable rises.
REQ-015 SHALL implement states IDLE, HDR, DATA, GAP.
REQ-016 IDLE + tick: SHALL snapshot the four channels and i_ch_mask into internal registers, then go to HDR next cycle.
REQ-017 Header word SHALL be {8'hA5, seq[7:0], 12'h000, mask[3:0]}; data word SHALL be {6'b110000, id[1:0], 8'h00, value[15:0]}.
REQ-018 In HDR/DATA with i_uart_full==0: SHALL present the word on o_uart_data with o_uart_wr=1 for exactly one cycle (registered), then go to GAP.
REQ-019 In HDR/DATA with i_uart_full==1: SHALL hold state, o_uart_wr=0, and retry each cycle without limit.
REQ-020 GAP SHALL last exactly one cycle, then go to DATA for the next set snapshot-mask bit in ascending id order, or to IDLE if none remain; minimum 2 cycles per word.
REQ-021 Snapshot mask==0 SHALL produce a header-only frame.
REQ-022 o_seq SHALL increment by 1 when the header write is issued, wrapping 255->0.
REQ-023 A tick in any state other than IDLE SHALL be dropped; o_overrun_cnt SHALL increment, saturating at 255.
REQ-024 Input or mask changes during a frame SHALL NOT affect it; only snapshot values are sent.
REQ-025 i_enable falling mid-frame SHALL let the current frame complete.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 o_uart_data SHALL retain its last value when o_uart_wr==0.

Reset
REQ-028 On reset==1 at a clock edge, next cycle SHALL show: state IDLE, tick counter 0, o_uart_wr 0, o_uart_data 0, o_busy 0, o_seq 0, o_overrun_cnt 0.
REQ-029 Reset mid-frame SHALL abort the frame with no further writes; reset coincident with tick SHALL win and no snapshot SHALL occur.

Verification (TICK_DIV=16)
REQ-030 Enable high, mask 4'b0001, velocity 16'd150, full 0 -> 2 writes per tick: 32'hA5000001, then 32'hC000_0096; seq goes 0->1.
REQ-031 Mask 4'b1111, setpoint 175, error 16'hFFF6, un 16'h1234 -> header, then words with ids 0,1,2,3 in order; each wr strobe exactly 1 cycle; at least 1 idle cycle between strobes.
REQ-032 Hold i_uart_full=1 for 40 cycles after the header -> no strobe while full; the frame resumes with the correct next word; two ticks dropped; o_overrun_cnt=2.
REQ-033 Mask 0 -> header-only frame 32'hA5xx0000; 256 frames -> o_seq wraps to 0.
REQ-034 Assert reset between data words -> o_uart_wr stays 0; all outputs 0 next cycle; the next frame header carries seq 0.
REQ-035 Force 300 overruns -> o_overrun_cnt saturates at 255.

Source files
------------

// File: rtl/telemetry_scheduler.sv
// Periodic telemetry framer: on each sample tick, snapshots four 16-bit channels
// and emits a header word plus one word per enabled channel to a UART TX FIFO.
module telemetry_scheduler #(
  parameter int TICK_DIV = 4096
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [3:0]  i_ch_mask,
  input  logic [15:0] i_velocity,
  input  logic [15:0] i_setpoint,
  input  logic [15:0] i_error,
  input  logic [15:0] i_un,
  input  logic        i_uart_full,
  output logic [31:0] o_uart_data,
  output logic        o_uart_wr,
  output logic        o_busy,
  output logic [7:0]  o_seq,
  output logic [7:0]  o_overrun_cnt
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0][15:0]  snap_q, snap_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        rem_q, rem_d;
  logic [1:0]        id_q, id_d;
  logic [1:0]        nxt_id;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              tick;

  assign tick = i_enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (i_enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Lowest pending channel id goes first.
  always_comb begin
    nxt_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rem_q[i]) nxt_id = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    id_d    = id_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    seq_d   = seq_q;
    ovr_d   = ovr_q;

    if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          snap_d  = {i_un, i_error, i_setpoint, i_velocity};
          mask_d  = i_ch_mask;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!i_uart_full) begin
          data_d  = {8'hA5, seq_q, 12'h000, mask_q};
          wr_d    = 1'b1;
          seq_d   = seq_q + 8'd1;
          rem_d   = mask_q;
          state_d = S_GAP;
        end
      end
      S_DATA: begin
        if (!i_uart_full) begin
          data_d      = {6'b110000, id_q, 8'h00, snap_q[id_q]};
          wr_d        = 1'b1;
          rem_d[id_q] = 1'b0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (rem_q != 4'b0000) begin
          id_d    = nxt_id;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset has priority over a coincident tick, so no snapshot is taken.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      seq_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_uart_data   = data_q;
  assign o_uart_wr     = wr_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_seq         = seq_q;
  assign o_overrun_cnt = ovr_q;

endmodule
